// File: rtl/dds_phase_acc.sv
// DDS phase accumulator with optional linear frequency glide.
// Ports: CLK, RESET (async, active-low), sample_en tick, freq_word/
//   freq_valid/freq_ready handshake, sync_in hard sync, DDS phase out,
//   phase_valid and wrap pulses, inc_cur increment in use (debug).
module dds_phase_acc #(
    parameter int          GLIDE_SHIFT = 4,
    parameter logic [31:0] PHASE_INIT  = 32'h0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        sample_en,
    input  logic [31:0] freq_word,
    input  logic        freq_valid,
    output logic        freq_ready,
    input  logic        sync_in,
    output logic [31:0] DDS,
    output logic        phase_valid,
    output logic        wrap,
    output logic [31:0] inc_cur
);

    localparam int CW = GLIDE_SHIFT + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(1) << GLIDE_SHIFT;

    typedef enum logic {
        IDLE  = 1'b0,
        GLIDE = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     inc_q;
    logic [31:0]     inc_d;
    logic [31:0]     tgt_q;
    logic [31:0]     tgt_d;
    logic [31:0]     step_q;
    logic [31:0]     step_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            rdy_q;
    logic [31:0]     phase_q;
    logic            wrap_q;
    logic            pv_q;
    logic            xfer;
    logic signed [32:0] diff;
    logic [32:0]     sum;

    // rdy_q delays acceptance by one edge after reset release so the
    // handshake never sees a partially released reset.
    assign freq_ready = rdy_q & RESET & (state_q == IDLE);
    assign xfer       = freq_valid & freq_ready;

    // 33-bit signed distance from the current to the requested increment.
    assign diff = $signed({1'b0, freq_word}) - $signed({1'b0, inc_q});

    assign sum = {1'b0, phase_q} + {1'b0, inc_q};

    always_comb begin
        state_d = state_q;
        inc_d   = inc_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (xfer && (freq_word != inc_q)) begin
                    if (GLIDE_SHIFT == 0) begin
                        inc_d = freq_word;
                    end else begin
                        tgt_d   = freq_word;
                        step_d  = 32'(diff >>> GLIDE_SHIFT);
                        cnt_d   = CNT_LOAD;
                        state_d = GLIDE;
                    end
                end
            end
            GLIDE: begin
                if (sample_en) begin
                    cnt_d = cnt_q - CW'(1);
                    // Last step snaps to the target, absorbing the
                    // truncation of the shifted step.
                    if (cnt_q == CW'(1)) begin
                        inc_d   = tgt_q;
                        state_d = IDLE;
                    end else begin
                        inc_d = inc_q + step_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            inc_q   <= 32'h0;
            tgt_q   <= 32'h0;
            step_q  <= 32'h0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inc_q   <= inc_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            rdy_q   <= 1'b1;
        end
    end

    // The phase adds the increment held before this edge, so a
    // same-cycle transfer only affects later ticks.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            phase_q <= PHASE_INIT;
            wrap_q  <= 1'b0;
            pv_q    <= 1'b0;
        end else if (sync_in) begin
            phase_q <= PHASE_INIT;
            wrap_q  <= 1'b0;
            pv_q    <= 1'b1;
        end else if (sample_en) begin
            phase_q <= sum[31:0];
            wrap_q  <= sum[32];
            pv_q    <= 1'b1;
        end else begin
            wrap_q  <= 1'b0;
            pv_q    <= 1'b0;
        end
    end

    assign DDS         = phase_q;
    assign wrap        = wrap_q;
    assign phase_valid = pv_q;
    assign inc_cur     = inc_q;

endmodule

// File: tb/tb_dds_phase_acc.sv
// Bench for dds_phase_acc: an immediate-step unit and a 4-tick glide
// unit share clock, reset, ticks and sync; phase outputs are scoreboarded.
module tb_dds_phase_acc;

    localparam logic [31:0] INIT0 = 32'h0;
    localparam logic [31:0] INIT2 = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] dds;
        logic        wrap;
    } exp_t;

    logic        CLK;
    logic        RESET;
    logic        sample_en;
    logic        sync_in;
    logic [31:0] fw0;
    logic        fv0;
    logic        fr0;
    logic [31:0] dds0;
    logic        pv0;
    logic        wr0;
    logic [31:0] inc0;
    logic [31:0] fw2;
    logic        fv2;
    logic        fr2;
    logic [31:0] dds2;
    logic        pv2;
    logic        wr2;
    logic [31:0] inc2;

    exp_t        q0[$];
    exp_t        q2[$];
    logic [31:0] p0;
    logic [31:0] p2;
    logic [31:0] m0;
    logic [31:0] m2;
    int          total = 0;
    int          bad = 0;

    dds_phase_acc #(.GLIDE_SHIFT(0), .PHASE_INIT(INIT0)) u0 (
        .CLK(CLK), .RESET(RESET), .sample_en(sample_en),
        .freq_word(fw0), .freq_valid(fv0), .freq_ready(fr0),
        .sync_in(sync_in), .DDS(dds0), .phase_valid(pv0),
        .wrap(wr0), .inc_cur(inc0)
    );

    dds_phase_acc #(.GLIDE_SHIFT(2), .PHASE_INIT(INIT2)) u2 (
        .CLK(CLK), .RESET(RESET), .sample_en(sample_en),
        .freq_word(fw2), .freq_valid(fv2), .freq_ready(fr2),
        .sync_in(sync_in), .DDS(dds2), .phase_valid(pv2),
        .wrap(wr2), .inc_cur(inc2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; drives one cycle and returns at the next.
    task automatic tick(input logic se, input logic sy);
        exp_t e;
        sample_en = se;
        sync_in   = sy;
        if (sy) begin
            p0 = INIT0;
            e.dds = p0; e.wrap = 1'b0; q0.push_back(e);
            p2 = INIT2;
            e.dds = p2; e.wrap = 1'b0; q2.push_back(e);
        end else if (se) begin
            {e.wrap, e.dds} = {1'b0, p0} + {1'b0, m0};
            p0 = e.dds; q0.push_back(e);
            {e.wrap, e.dds} = {1'b0, p2} + {1'b0, m2};
            p2 = e.dds; q2.push_back(e);
        end
        @(negedge CLK);
        sample_en = 1'b0;
        sync_in   = 1'b0;
    endtask

    task automatic gstep(input string tag, input logic [31:0] exp);
        tick(1'b1, 1'b0);
        chk(tag, inc2, exp);
        m2 = exp;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (pv0) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $error("FAIL u0_extra: got pulse want none");
            end else begin
                e = q0.pop_front();
                chk("u0_dds", dds0, e.dds);
                chk("u0_wrap", 32'(wr0), 32'(e.wrap));
            end
        end else if (RESET) begin
            chk("u0_wrap_idle", 32'(wr0), 32'h0);
        end
        if (pv2) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $error("FAIL u2_extra: got pulse want none");
            end else begin
                e = q2.pop_front();
                chk("u2_dds", dds2, e.dds);
                chk("u2_wrap", 32'(wr2), 32'(e.wrap));
            end
        end
    end

    initial begin
        RESET = 1'b0; sample_en = 1'b0; sync_in = 1'b0;
        fw0 = 32'h0; fv0 = 1'b0; fw2 = 32'h0; fv2 = 1'b0;
        p0 = INIT0; p2 = INIT2; m0 = 32'h0; m2 = 32'h0;
        repeat (3) @(negedge CLK);
        chk("rst_dds0", dds0, INIT0);
        chk("rst_dds2", dds2, INIT2);
        chk("rst_inc0", inc0, 32'h0);
        chk("rst_pv0", 32'(pv0), 32'h0);
        chk("rst_wrap0", 32'(wr0), 32'h0);
        chk("rst_rdy0", 32'(fr0), 32'h0);
        RESET = 1'b1;
        #1;
        chk("sync_rdy0", 32'(fr0), 32'h0);
        @(negedge CLK);
        chk("rel_rdy0", 32'(fr0), 32'h1);
        chk("rel_rdy2", 32'(fr2), 32'h1);

        // Immediate increment, four ticks with a wrap on the last.
        fw0 = 32'h4000_0000; fv0 = 1'b1;
        tick(1'b0, 1'b0);
        fv0 = 1'b0;
        chk("imm_inc0", inc0, 32'h4000_0000);
        m0 = 32'h4000_0000;
        repeat (4) tick(1'b1, 1'b0);

        // Transfer coincident with a tick uses the old increment.
        fw0 = 32'h0000_1234; fv0 = 1'b1;
        tick(1'b1, 1'b0);
        fv0 = 1'b0;
        chk("coin_inc0", inc0, 32'h0000_1234);
        m0 = 32'h0000_1234;
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        chk("pre_sync_dds0", dds0, 32'h0000_1234);
        tick(1'b1, 1'b1);

        // Upward glide; a new word waits while the glide runs.
        fw2 = 32'h0000_0100; fv2 = 1'b1;
        tick(1'b0, 1'b0);
        fw2 = 32'h0;
        chk("glide_rdy", 32'(fr2), 32'h0);
        chk("glide_inc0", inc2, 32'h0);
        gstep("up1", 32'h40);
        tick(1'b0, 1'b0);
        chk("up_hold", inc2, 32'h40);
        chk("up_hold_rdy", 32'(fr2), 32'h0);
        tick(1'b0, 1'b1);
        chk("up_sync", inc2, 32'h40);
        gstep("up2", 32'h80);
        gstep("up3", 32'hC0);
        gstep("up4", 32'h100);
        chk("up_done_rdy", 32'(fr2), 32'h1);

        // The held word (0) transfers now: downward glide.
        tick(1'b0, 1'b0);
        fv2 = 1'b0;
        chk("dn_rdy", 32'(fr2), 32'h0);
        gstep("dn1", 32'hC0);
        gstep("dn2", 32'h80);
        gstep("dn3", 32'h40);
        gstep("dn4", 32'h0);
        chk("dn_done_rdy", 32'(fr2), 32'h1);

        // Uneven glide ends exactly on target.
        fw2 = 32'h0000_0103; fv2 = 1'b1;
        tick(1'b0, 1'b0);
        fv2 = 1'b0;
        gstep("odd1", 32'h40);
        gstep("odd2", 32'h80);
        gstep("odd3", 32'hC0);
        gstep("odd4", 32'h103);

        // Same word again must not start a glide.
        fv2 = 1'b1;
        tick(1'b0, 1'b0);
        fv2 = 1'b0;
        chk("same_rdy", 32'(fr2), 32'h1);

        // Reset in the middle of a glide.
        fw2 = 32'h0; fv2 = 1'b1;
        tick(1'b0, 1'b0);
        fv2 = 1'b0;
        tick(1'b1, 1'b0);
        #2;
        RESET = 1'b0;
        #1;
        chk("mid_dds2", dds2, INIT2);
        chk("mid_inc2", inc2, 32'h0);
        chk("mid_pv2", 32'(pv2), 32'h0);
        chk("mid_wrap2", 32'(wr2), 32'h0);
        chk("mid_rdy2", 32'(fr2), 32'h0);
        chk("mid_dds0", dds0, INIT0);
        p0 = INIT0; p2 = INIT2; m0 = 32'h0; m2 = 32'h0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("rel2_rdy2", 32'(fr2), 32'h1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("abort_inc2", inc2, 32'h0);

        @(negedge CLK);
        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q2_drained", 32'(q2.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
